// File: rtl/seq_slice_adder_pkg.sv
// Shared definitions for the sequential slice adder: FSM states and default geometry.
package seq_slice_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_SLICE = 8;

endpackage

// File: rtl/slice_cla_adder.sv
// SLICE-bit carry-lookahead adder; also exposes the carry into its MSB for overflow detection.
module slice_cla_adder #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [SLICE-1:0] gen;
    logic [SLICE-1:0] prop;
    logic [SLICE:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is the flat OR of every generate term propagated up to it,
    // so no carry depends on the one below it.
    always_comb begin
        logic term;
        logic pacc;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            term = 1'b0;
            pacc = 1'b1;
            for (int j = SLICE - 1; j >= 0; j--) begin
                if (j <= i) begin
                    term = term | (pacc & gen[j]);
                    pacc = pacc & prop[j];
                end
            end
            carry[i+1] = term | (pacc & cin);
        end
    end

    assign sum  = prop ^ carry[SLICE-1:0];
    assign cout = carry[SLICE];
    assign cmsb = carry[SLICE-1];

endmodule

// File: rtl/seq_slice_adder.sv
// Multi-cycle adder/subtractor resolving one SLICE-bit slice per cycle through a shared lookahead slice.
module seq_slice_adder
    import seq_slice_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int NSLICES = WIDTH / SLICE;
    localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSLICES - 1);

    state_e           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CNT_W-1:0] idx_q;

    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;

    slice_cla_adder #(.SLICE(SLICE)) u_slice (
        .a    (a_q[idx_q*SLICE +: SLICE]),
        .b    (b_q[idx_q*SLICE +: SLICE]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .cmsb (slice_cmsb)
    );

    // Subtraction is folded in at accept time: B is inverted and the initial carry is 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            sum_o   <= '0;
            cout_o  <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i ^ {WIDTH{sub_i}};
                        carry_q <= sub_i;
                        idx_q   <= '0;
                        ready_o <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        sum_o[idx_q*SLICE +: SLICE] <= slice_sum;
                        carry_q <= slice_cout;
                        idx_q   <= idx_q + CNT_W'(1);
                        if (idx_q == LAST_IDX) begin
                            cout_o  <= slice_cout;
                            ovf_o   <= slice_cout ^ slice_cmsb;
                            valid_o <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush_i || ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_slice_adder.sv
// Randomised and directed bench for seq_slice_adder against an arithmetic reference model.
module tb_seq_slice_adder;

    localparam int W       = 64;
    localparam int LATENCY = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         sub_i;
    logic         flush_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;

    int errors = 0;
    int checks = 0;

    seq_slice_adder dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .sub_i   (sub_i),
        .flush_i (flush_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference result from plain arithmetic: cout is "no borrow" for subtraction.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] sum, output logic cout, output logic ovf);
        logic [W:0] wide;
        if (s) begin
            sum  = a - b;
            cout = (a >= b);
            ovf  = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            sum  = wide[W-1:0];
            cout = wide[W];
            ovf  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        end
    endtask

    // Accepts one request (DUT must be idle) and waits for valid_o; lat = -1 on timeout.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat);
        a_i = a; b_i = b; sub_i = s; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom}; sub_i = $urandom_range(0, 1);
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk_i); #1;
            if (valid_o) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_result();
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
        a_i = '0; b_i = '0; sub_i = 1'b0;
        #12;
        checks++;
        if ({ready_o, valid_o, cout_o, ovf_o} !== 4'b1000 || sum_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got rdy=%b vld=%b c=%b o=%b sum=%h, want 1 0 0 0 0",
                     ready_o, valid_o, cout_o, ovf_o, sum_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    // Directed vectors exercising slice carry crossing, wraparound, overflow and borrow.
    task automatic test_directed();
        logic [W-1:0] va [4] = '{64'h00000000000000FF, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'h7FFF_FFFF_FFFF_FFFF, 64'd5};
        logic [W-1:0] vb [4] = '{64'd1, 64'd1, 64'd1, 64'd7};
        logic         vs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] esum [4] = '{64'h100, 64'h0, 64'h8000_0000_0000_0000,
                                   64'hFFFF_FFFF_FFFF_FFFE};
        logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic         eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vs[i], lat);
            checks++;
            if (lat !== LATENCY || sum_o !== esum[i] || cout_o !== ec[i] || ovf_o !== eo[i]) begin
                errors++;
                $display("[TB] FAIL directed_%0d: got lat=%0d sum=%h c=%b o=%b, want lat=%0d sum=%h c=%b o=%b",
                         i, lat, sum_o, cout_o, ovf_o, LATENCY, esum[i], ec[i], eo[i]);
            end
            release_result();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, es;
        logic s, ec, eo;
        int lat;
        for (int i = 0; i < 20; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 4 == 0) b = ~a;
            if (i % 4 == 1) b = a;
            s = $urandom_range(0, 1);
            model(a, b, s, es, ec, eo);
            run_op(a, b, s, lat);
            checks++;
            if (lat !== LATENCY || sum_o !== es || cout_o !== ec || ovf_o !== eo) begin
                errors++;
                $display("[TB] FAIL random_%0d: a=%h b=%h sub=%b got lat=%0d sum=%h c=%b o=%b, want lat=%0d sum=%h c=%b o=%b",
                         i, a, b, s, lat, sum_o, cout_o, ovf_o, LATENCY, es, ec, eo);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, es;
        logic ec, eo;
        int lat;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        model(a, b, 1'b0, es, ec, eo);
        run_op(a, b, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || sum_o !== es || cout_o !== ec || ovf_o !== eo) begin
                errors++;
                $display("[TB] FAIL hold_%0d: got vld=%b rdy=%b sum=%h c=%b o=%b, want 1 0 %h %b %b",
                         i, valid_o, ready_o, sum_o, cout_o, ovf_o, es, ec, eo);
            end
            @(posedge clk_i); #1;
        end
        release_result();
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_release: got rdy=%b vld=%b, want 1 0", ready_o, valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] es;
        logic ec, eo;
        int lat;
        run_op(64'd10, 64'd20, 1'b0, lat);
        // Request already pending while the result drains; it must not be taken that same edge.
        a_i = 64'd100; b_i = 64'd1; sub_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: got rdy=%b vld=%b, want 1 0", ready_o, valid_o);
        end
        model(64'd100, 64'd1, 1'b1, es, ec, eo);
        run_op(64'd100, 64'd1, 1'b1, lat);
        checks++;
        if (lat !== LATENCY || sum_o !== es || cout_o !== ec) begin
            errors++;
            $display("[TB] FAIL b2b_result: got lat=%0d sum=%h c=%b, want %0d %h %b",
                     lat, sum_o, cout_o, LATENCY, es, ec);
        end
        release_result();
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom}; sub_i = 1'b0; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_run: got rdy=%b vld=%b, want 1 0", ready_o, valid_o);
        end
        seen = 0;
        repeat (12) begin
            @(posedge clk_i); #1;
            if (valid_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("[TB] FAIL flush_no_valid: got %0d valid cycles, want 0", seen);
        end
        // flush_i asserted in IDLE must not block the accept.
        flush_i = 1'b1;
        a_i = 64'd3; b_i = 64'd4; sub_i = 1'b0; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk_i); #1;
            if (valid_o) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== LATENCY || sum_o !== 64'd7) begin
            errors++;
            $display("[TB] FAIL flush_then_op: got lat=%0d sum=%h, want %0d 7", lat, sum_o, LATENCY);
        end
        flush_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0; ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_done: got rdy=%b vld=%b, want 1 0", ready_o, valid_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] a, b, es;
        logic ec, eo;
        int lat;
        a_i = 64'h7FFF_FFFF_FFFF_FFFF; b_i = 64'd1; sub_i = 1'b0; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({ready_o, valid_o, cout_o, ovf_o} !== 4'b1000 || sum_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got rdy=%b vld=%b c=%b o=%b sum=%h, want 1 0 0 0 0",
                     ready_o, valid_o, cout_o, ovf_o, sum_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        model(a, b, 1'b1, es, ec, eo);
        run_op(a, b, 1'b1, lat);
        checks++;
        if (lat !== LATENCY || sum_o !== es || cout_o !== ec || ovf_o !== eo) begin
            errors++;
            $display("[TB] FAIL reset_recover: got lat=%0d sum=%h c=%b o=%b, want %0d %h %b %b",
                     lat, sum_o, cout_o, ovf_o, LATENCY, es, ec, eo);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
